// File: rtl/soc_end_monitor.sv
// soc_end_monitor: multi-channel end-of-test monitor with watchdog.
// Latches each channel's result on its first completion flag, cross-checks
// all latched results against channel 0 and reports a sticky verdict.
// Optional feature macro: SOC_MON_SKEW_EN adds a COLLECT state that lets
// channels complete up to SKEW_MAX cycles apart; without it any
// non-simultaneous completion is a mismatch (strict lockstep).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for fetch_en_i
// RUN     | counting cycles, waiting for the first channel flag
// COLLECT | some channels done, waiting for the rest (skew build only)
// DONE    | verdict latched, all outputs frozen until reset

module soc_end_monitor #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 24,
    parameter int SKEW_MAX   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fetch_en_i,
    input  logic [CNT_WIDTH-1:0]         timeout_i,
    input  logic [NUM_CH-1:0]            flag_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] result_i,
    output logic [NUM_CH-1:0]            ch_done_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         mismatch_o,
    output logic                         timeout_o,
    output logic [DATA_WIDTH-1:0]        result_o,
    output logic [CNT_WIDTH-1:0]         cycles_o
);

`ifdef SOC_MON_SKEW_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_COLLECT, S_DONE} state_t;
    localparam int SKEW_W = $clog2(SKEW_MAX + 1);
    logic [SKEW_W-1:0] skew_q;
    logic              collect_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t                  state_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [NUM_CH-1:0]       ch_done_q;
    logic [DATA_WIDTH-1:0]   res_q [NUM_CH];
    logic                    done_q, pass_q, mismatch_q, timeout_q;

    logic                    running_d;
    logic [NUM_CH-1:0]       cap_d;
    logic [NUM_CH-1:0]       lat_d;
    logic                    all_done_d;
    logic                    wd_hit_d;
    logic [CNT_WIDTH-1:0]    cnt_d;
    logic [DATA_WIDTH-1:0]   res_d [NUM_CH];
    logic                    differ_d;
    logic                    fin_d, fin_mm_d, fin_to_d;

    // Capture, watchdog and verdict decisions for the current cycle
    always_comb begin
        running_d = (state_q == S_RUN);
`ifdef SOC_MON_SKEW_EN
        running_d = running_d || (state_q == S_COLLECT);
`endif
        cap_d      = running_d ? (flag_i & ~ch_done_q) : '0;
        all_done_d = &(ch_done_q | cap_d);
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        wd_hit_d   = running_d && (timeout_i != '0) &&
                     (({1'b0, cnt_q} + (CNT_WIDTH+1)'(1)) == {1'b0, timeout_i});
        // A watchdog expiry freezes the channel set unless this edge completes it
        lat_d      = (wd_hit_d && !all_done_d) ? '0 : cap_d;
        for (int c = 0; c < NUM_CH; c++) begin
            res_d[c] = lat_d[c] ? result_i[c*DATA_WIDTH +: DATA_WIDTH] : res_q[c];
        end
        differ_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((ch_done_q[c] || lat_d[c]) && (res_d[c] != res_d[0])) begin
                differ_d = 1'b1;
            end
        end
        fin_d    = 1'b0;
        fin_mm_d = 1'b0;
        fin_to_d = 1'b0;
`ifdef SOC_MON_SKEW_EN
        collect_d = 1'b0;
`endif
        if (running_d) begin
            if (all_done_d) begin
                fin_d    = 1'b1;
                fin_mm_d = differ_d;
            end else if (wd_hit_d) begin
                fin_d    = 1'b1;
                fin_to_d = 1'b1;
                fin_mm_d = differ_d;
            end else if ((state_q == S_RUN) && (|cap_d)) begin
`ifdef SOC_MON_SKEW_EN
                collect_d = 1'b1;
`else
                fin_d    = 1'b1;
                fin_mm_d = 1'b1;
`endif
            end
`ifdef SOC_MON_SKEW_EN
            else if ((state_q == S_COLLECT) && (skew_q >= SKEW_W'(SKEW_MAX))) begin
                fin_d    = 1'b1;
                fin_mm_d = 1'b1;
            end
`endif
        end
    end

    // Sequencer FSM with registered verdict, counters and result latches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ch_done_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) res_q[c] <= '0;
`ifdef SOC_MON_SKEW_EN
            skew_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_en_i) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end
                end
                S_DONE: ;
                default: begin
                    cnt_q     <= cnt_d;
                    ch_done_q <= ch_done_q | lat_d;
                    for (int c = 0; c < NUM_CH; c++) res_q[c] <= res_d[c];
                    if (fin_d) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        mismatch_q <= fin_mm_d;
                        timeout_q  <= fin_to_d;
                        pass_q     <= ~fin_mm_d & ~fin_to_d;
                    end
`ifdef SOC_MON_SKEW_EN
                    else if (collect_d) begin
                        state_q <= S_COLLECT;
                        skew_q  <= SKEW_W'(1);
                    end else if (state_q == S_COLLECT) begin
                        skew_q  <= skew_q + SKEW_W'(1);
                    end
`endif
                end
            endcase
        end
    end

    assign ch_done_o  = ch_done_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign mismatch_o = mismatch_q;
    assign timeout_o  = timeout_q;
    assign result_o   = res_q[0];
    assign cycles_o   = cnt_q;

endmodule

// File: tb/tb_soc_end_monitor.sv
// tb_soc_end_monitor: scoreboard bench for soc_end_monitor (3 channels).
// Works for both builds; expectations follow SOC_MON_SKEW_EN.

module tb_soc_end_monitor;

    localparam int NUM_CH = 3;
    localparam int DW     = 32;
    localparam int CW     = 24;
    localparam int SKEW   = 4;
    localparam int NEVER  = 100000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              fetch_en_i;
    logic [CW-1:0]     timeout_i;
    logic [NUM_CH-1:0] flag_i;
    logic [NUM_CH*DW-1:0] result_i;
    logic [NUM_CH-1:0] ch_done_o;
    logic              done_o, pass_o, mismatch_o, timeout_o;
    logic [DW-1:0]     result_o;
    logic [CW-1:0]     cycles_o;

    soc_end_monitor #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .SKEW_MAX(SKEW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_en_i(fetch_en_i), .timeout_i(timeout_i),
        .flag_i(flag_i), .result_i(result_i), .ch_done_o(ch_done_o), .done_o(done_o),
        .pass_o(pass_o), .mismatch_o(mismatch_o), .timeout_o(timeout_o),
        .result_o(result_o), .cycles_o(cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [2:0]  chd;
        logic        pass_v;
        logic        mm;
        logic        to;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          fa[NUM_CH];
    logic [31:0] rv[NUM_CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Timing model: when the run ends, which channels were latched, verdict
    function automatic exp_t model(input string tag, input int t);
        exp_t        e;
        int          f, l, tc;
        bit          full;
        logic [2:0]  lat;
        logic [31:0] ref0;
        f = NEVER; l = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fa[c] < f) f = fa[c];
            if (fa[c] > l) l = fa[c];
        end
`ifdef SOC_MON_SKEW_EN
        if (l - f <= SKEW) begin tc = l; full = 1; end
        else begin tc = f + SKEW; full = 0; end
`else
        tc = f; full = (l == f);
`endif
        if (f == NEVER) begin tc = NEVER; full = 0; end
        e.tag = tag;
        e.to  = (t != 0) && (t < tc);
        e.cyc = e.to ? t : tc;
        for (int c = 0; c < NUM_CH; c++) lat[c] = e.to ? (fa[c] < t) : (fa[c] <= tc);
        e.mm  = !full && !e.to;
        ref0  = lat[0] ? rv[0] : 32'h0;
        for (int c = 0; c < NUM_CH; c++) if (lat[c] && rv[c] != ref0) e.mm = 1'b1;
        e.chd    = lat;
        e.res    = ref0;
        e.pass_v = !e.mm && !e.to;
        return e;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1; fetch_en_i = 1'b0; flag_i = '0; timeout_i = '0; result_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic set_case(input int a, input int b, input int c,
                            input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        fa[0] = a; fa[1] = b; fa[2] = c;
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
    endtask

    // Flag "at cycle N" means high during the RUN cycle where cycles_o = N-1
    task automatic run_case(input string tag, input int t);
        exp_t e;
        int   k;
        do_reset();
        sb.push_back(model(tag, t));
        timeout_i  = CW'(t);
        result_i   = {rv[2], rv[1], rv[0]};
        fetch_en_i = 1'b1;
        @(negedge clk_i);
        fetch_en_i = 1'b0;
        check({tag, ":cyc0"}, cycles_o, 0);
        k = 0;
        while (!done_o && k < 2000) begin
            for (int c = 0; c < NUM_CH; c++) flag_i[c] = (k + 1 >= fa[c]);
            @(negedge clk_i);
            k++;
        end
        check({tag, ":done"}, done_o, 1);
        e = sb.pop_front();
        check({e.tag, ":cycles"},  cycles_o,   e.cyc);
        check({e.tag, ":ch_done"}, ch_done_o,  e.chd);
        check({e.tag, ":pass"},    pass_o,     e.pass_v);
        check({e.tag, ":mism"},    mismatch_o, e.mm);
        check({e.tag, ":tmo"},     timeout_o,  e.to);
        check({e.tag, ":result"},  result_o,   e.res);
        // Outputs stay frozen in DONE regardless of inputs
        result_i = ~result_i; flag_i = '1; fetch_en_i = 1'b1;
        repeat (3) @(negedge clk_i);
        fetch_en_i = 1'b0;
        check({e.tag, ":frz_cyc"}, cycles_o, e.cyc);
        check({e.tag, ":frz_res"}, result_o, e.res);
        check({e.tag, ":frz_chd"}, ch_done_o, e.chd);
    endtask

    initial begin
        rst_i = 1'b1; fetch_en_i = 1'b0; flag_i = '0; timeout_i = '0; result_i = '0;
        #3;
        check("rst:done", done_o, 0);
        check("rst:cycles", cycles_o, 0);
        check("rst:chd", ch_done_o, 0);
        check("rst:result", result_o, 0);

        set_case(20, 20, 20, 32'h2A, 32'h2A, 32'h2A);         run_case("all20", 100);
        set_case(20, 20, 20, 32'h2A, 32'h2A, 32'h2B);         run_case("ch2diff", 100);
        set_case(20, 20, 20, 32'h55, 32'h2A, 32'h2A);         run_case("ch0diff", 100);
        set_case(NEVER, NEVER, NEVER, 32'h1, 32'h1, 32'h1);   run_case("tmo50", 50);
        set_case(NEVER, NEVER, NEVER, 32'h1, 32'h1, 32'h1);   run_case("tmo1", 1);
        set_case(10, 10, 13, 32'h77, 32'h77, 32'h77);         run_case("skew3", 100);
        set_case(10, 10, 15, 32'h77, 32'h77, 32'h77);         run_case("skew5", 100);
        set_case(30, 30, 30, 32'h9, 32'h9, 32'h9);            run_case("tie30", 30);
        set_case(31, 31, 31, 32'h9, 32'h9, 32'h9);            run_case("late31", 30);
        set_case(500, 500, 500, 32'hCAFE, 32'hCAFE, 32'hCAFE); run_case("nowd500", 0);
        set_case(1, 1, 1, 32'h7, 32'h7, 32'h7);               run_case("first1", 0);

        // Asynchronous reset in the middle of a run
        do_reset();
        timeout_i = '0; flag_i = '0; result_i = '0;
        fetch_en_i = 1'b1;
        @(negedge clk_i);
        fetch_en_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("mid:cycles40", cycles_o, 40);
        #2 rst_i = 1'b1;
        #1;
        check("mid:cycles", cycles_o, 0);
        check("mid:done", done_o, 0);
        check("mid:chd", ch_done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_case(5, 5, 5, 32'h3, 32'h3, 32'h3);               run_case("after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
